proximity_filter: RTL and testbench

Downstream consumer of the ultrasonic ranging stage. Accepts raw distance samples (cm) with a one-cycle valid strobe and smooths them with a power-of-two moving average. Applies a hysteresis threshold with N-sample confirmation and a freshness timeout, then presents a debounced `near` level plus a one-cycle `near_rise` event to the game/pet logic. Replaces ad-hoc single-sample LED thresholding with a stable presence signal.

---
 rtl/proximity_pkg.sv | 23 ++
 rtl/moving_avg.sv | 90 +++++++++
 rtl/proximity_filter.sv | 171 +++++++++++++++++
 tb/tb_proximity_filter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proximity_pkg.sv
// Shared types and parameter-derivation helpers for the proximity filter.
package proximity_pkg;

    typedef enum logic [1:0] {
        ST_FAR       = 2'd0,
        ST_NEAR_PEND = 2'd1,
        ST_NEAR      = 2'd2,
        ST_FAR_PEND  = 2'd3
    } prox_state_e;

    function automatic int dist_max(input int dist_w);
        return (1 << dist_w) - 1;
    endfunction

    function automatic int timeout_cyc(input int clk_hz, input int timeout_ms);
        return clk_hz / 1000 * timeout_ms;
    endfunction

    function automatic int sum_w(input int dist_w, input int avg_log2);
        return dist_w + avg_log2;
    endfunction

endpackage

// File: rtl/moving_avg.sv
// Saturating power-of-two moving average: ring buffer plus running sum,
// registered average one cycle after the sample lands in the buffer.
module moving_avg
    import proximity_pkg::*;
#(
    parameter int DIST_W   = 9,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       distance_in,
    input  logic              sample_valid,
    input  logic              flush,
    output logic [DIST_W-1:0] avg_cm,
    output logic              avg_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    // A depth-1 buffer still needs a 1-bit pointer; the spare slot is never read.
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam int SUM_W = sum_w(DIST_W, AVG_LOG2);
    localparam logic [DIST_W-1:0] DMAX      = DIST_W'(dist_max(DIST_W));
    localparam logic [SUM_W-1:0]  SUM_FLUSH = SUM_W'(dist_max(DIST_W)) << AVG_LOG2;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [DIST_W-1:0] ring_q [SLOTS];
    logic [DIST_W-1:0] ring_d [SLOTS];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              smp_q, smp_d;
    logic [DIST_W-1:0] avg_q, avg_d;
    logic              avg_valid_q, avg_valid_d;
    logic [DIST_W-1:0] sample_sat;

    always_comb begin
        if (distance_in > 16'(DMAX)) begin
            sample_sat = DMAX;
        end else begin
            sample_sat = distance_in[DIST_W-1:0];
        end

        ring_d      = ring_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        smp_d       = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;

        if (flush) begin
            for (int i = 0; i < SLOTS; i++) ring_d[i] = DMAX;
            ptr_d = '0;
            sum_d = SUM_FLUSH;
            avg_d = DMAX;
        end else begin
            if (sample_valid) begin
                ring_d[ptr_q] = sample_sat;
                sum_d = sum_q - SUM_W'(ring_q[ptr_q]) + SUM_W'(sample_sat);
                ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                smp_d = 1'b1;
            end
            if (smp_q) begin
                avg_d       = DIST_W'(sum_q >> AVG_LOG2);
                avg_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) ring_q[i] <= DMAX;
            ptr_q       <= '0;
            sum_q       <= SUM_FLUSH;
            smp_q       <= 1'b0;
            avg_q       <= DMAX;
            avg_valid_q <= 1'b0;
        end else begin
            ring_q      <= ring_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            smp_q       <= smp_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_cm    = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/proximity_filter.sv
// Debounced presence detector: moving average, hysteresis with N-sample
// confirmation, and a freshness timeout that drops to FAR and flushes.
module proximity_filter
    import proximity_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DIST_W     = 9,
    parameter int AVG_LOG2   = 2,
    parameter int NEAR_CM    = 10,
    parameter int FAR_CM     = 15,
    parameter int CONFIRM    = 3,
    parameter int TIMEOUT_MS = 100
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       distance_in,
    input  logic              sample_valid,
    output logic [DIST_W-1:0] avg_cm,
    output logic              avg_valid,
    output logic              near,
    output logic              near_rise,
    output logic              stale
);

    localparam int TIMEOUT_CYC = timeout_cyc(CLK_HZ, TIMEOUT_MS);
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W       = $clog2(CONFIRM + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [DIST_W-1:0] NEAR_TH  = DIST_W'(NEAR_CM);
    localparam logic [DIST_W-1:0] FAR_TH   = DIST_W'(FAR_CM);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(CONFIRM);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              stale_q, stale_d;
    logic              expire;
    logic [DIST_W-1:0] avg_w;
    logic              avg_valid_w;
    prox_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              near_q, near_rise_q;

    // A sample arriving on the expiry cycle wins: reload, no timeout.
    always_comb begin
        expire  = 1'b0;
        tmo_d   = tmo_q;
        stale_d = stale_q;
        if (sample_valid) begin
            tmo_d   = TMO_LOAD;
            stale_d = 1'b0;
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
            if (tmo_q == TMO_ONE) begin
                expire  = 1'b1;
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q   <= TMO_LOAD;
            stale_q <= 1'b1;
        end else begin
            tmo_q   <= tmo_d;
            stale_q <= stale_d;
        end
    end

    moving_avg #(
        .DIST_W   (DIST_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clock        (clock),
        .reset_n      (reset_n),
        .distance_in  (distance_in),
        .sample_valid (sample_valid),
        .flush        (expire),
        .avg_cm       (avg_w),
        .avg_valid    (avg_valid_w)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FAR;
            cnt_q       <= '0;
            near_q      <= 1'b0;
            near_rise_q <= 1'b0;
        end else begin
            near_rise_q <= 1'b0;
            if (expire) begin
                state_q <= ST_FAR;
                cnt_q   <= '0;
                near_q  <= 1'b0;
            end else if (avg_valid_w) begin
                unique case (state_q)
                    ST_FAR: begin
                        if (avg_w <= NEAR_TH) begin
                            if (CONFIRM == 1) begin
                                state_q     <= ST_NEAR;
                                cnt_q       <= '0;
                                near_q      <= 1'b1;
                                near_rise_q <= 1'b1;
                            end else begin
                                state_q <= ST_NEAR_PEND;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    ST_NEAR_PEND: begin
                        if (avg_w <= NEAR_TH) begin
                            if (cnt_inc >= CNT_DONE) begin
                                state_q     <= ST_NEAR;
                                cnt_q       <= '0;
                                near_q      <= 1'b1;
                                near_rise_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            state_q <= ST_FAR;
                            cnt_q   <= '0;
                        end
                    end
                    ST_NEAR: begin
                        if (avg_w > FAR_TH) begin
                            if (CONFIRM == 1) begin
                                state_q <= ST_FAR;
                                cnt_q   <= '0;
                                near_q  <= 1'b0;
                            end else begin
                                state_q <= ST_FAR_PEND;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    ST_FAR_PEND: begin
                        if (avg_w > FAR_TH) begin
                            if (cnt_inc >= CNT_DONE) begin
                                state_q <= ST_FAR;
                                cnt_q   <= '0;
                                near_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            state_q <= ST_NEAR;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_FAR;
                        cnt_q   <= '0;
                        near_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign avg_cm    = avg_w;
    assign avg_valid = avg_valid_w;
    assign near      = near_q;
    assign near_rise = near_rise_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_proximity_filter.sv
// Two filters (averaging depth 4 and 1) share one stimulus stream; a
// sample-history reference model feeds per-instance scoreboards.
module tb_proximity_filter;

    localparam int NI      = 2;
    localparam int TMO     = 1000;
    localparam int NEAR_CM = 10;
    localparam int FAR_CM  = 15;
    localparam int CONFIRM = 3;

    typedef struct {
        int avg;
        bit nr;
        bit rise;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] distance_in = '0;
    logic        sample_valid = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    int   hist[$];
    int   idle;
    bit   exp_stale;
    bit   mnear [NI];
    int   mrun [NI];
    int   exp_rises [NI];
    int   seen_rises [NI];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    function automatic int lg(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : gi
            logic [8:0] avg_cm;
            logic       avg_valid, near, near_rise, stale;

            proximity_filter #(
                .CLK_HZ     (1_000_000),
                .DIST_W     (9),
                .AVG_LOG2   ((g == 0) ? 2 : 0),
                .NEAR_CM    (NEAR_CM),
                .FAR_CM     (FAR_CM),
                .CONFIRM    (CONFIRM),
                .TIMEOUT_MS (1)
            ) dut (
                .clock        (clock),
                .reset_n      (reset_n),
                .distance_in  (distance_in),
                .sample_valid (sample_valid),
                .avg_cm       (avg_cm),
                .avg_valid    (avg_valid),
                .near         (near),
                .near_rise    (near_rise),
                .stale        (stale)
            );

            initial begin : mon
                exp_t e;
                exp_t due_e;
                bit   due;
                due = 1'b0;
                forever begin
                    @(negedge clock);
                    if (due) begin
                        check($sformatf("near[%0d]", g), 32'(near), 32'(due_e.nr));
                        check($sformatf("near_rise[%0d]", g), 32'(near_rise), 32'(due_e.rise));
                        due = 1'b0;
                    end
                    if (near_rise === 1'b1) seen_rises[g]++;
                    check($sformatf("stale[%0d]", g), 32'(stale), 32'(exp_stale));
                    if (exp_stale) check($sformatf("near_while_stale[%0d]", g), 32'(near), 32'd0);
                    if (avg_valid === 1'b1) begin
                        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                            checks++;
                            errors++;
                            $display("FAIL avg_valid[%0d]: unexpected pulse with avg_cm=%0d, required none", g, avg_cm);
                        end else begin
                            if (g == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            check($sformatf("avg_cm[%0d]", g), 32'(avg_cm), 32'(e.avg));
                            due_e = e;
                            due   = 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Reference model: shared history of saturated samples; a flush is just
    // four DIST_MAX entries appended (covers both depths).
    function automatic int avg_of(input int l2);
        int s;
        int n;
        s = 0;
        n = 1 << l2;
        for (int k = 0; k < n; k++) s += hist[hist.size() - 1 - k];
        return s / n;
    endfunction

    task automatic push_max();
        repeat (4) hist.push_back(511);
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic present(input int i, input int a, output bit nr, output bit rise);
        rise = 1'b0;
        if (!mnear[i]) begin
            if (a <= NEAR_CM) mrun[i]++; else mrun[i] = 0;
            if (mrun[i] >= CONFIRM) begin
                mnear[i] = 1'b1;
                mrun[i]  = 0;
                rise     = 1'b1;
                exp_rises[i]++;
            end
        end else begin
            if (a > FAR_CM) mrun[i]++; else mrun[i] = 0;
            if (mrun[i] >= CONFIRM) begin
                mnear[i] = 1'b0;
                mrun[i]  = 0;
            end
        end
        nr = mnear[i];
    endtask

    task automatic model_reset();
        hist.delete();
        push_max();
        idle      = 0;
        exp_stale = 1'b1;
        for (int i = 0; i < NI; i++) begin
            mnear[i] = 1'b0;
            mrun[i]  = 0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   d;
        if (!reset_n) return;
        if (sample_valid) begin
            d = int'(distance_in);
            hist.push_back((d > 511) ? 511 : d);
            while (hist.size() > 8) void'(hist.pop_front());
            idle      = 0;
            exp_stale = 1'b0;
            for (int i = 0; i < NI; i++) begin
                e.avg = avg_of(lg(i));
                present(i, e.avg, e.nr, e.rise);
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end else if (idle < TMO) begin
            idle++;
            if (idle == TMO) begin
                exp_stale = 1'b1;
                push_max();
                for (int i = 0; i < NI; i++) begin
                    mnear[i] = 1'b0;
                    mrun[i]  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic send(input int d, input int gap);
        sample_valid = 1'b1;
        distance_in  = 16'(d);
        tick();
        sample_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, " avg_cm[0]"},    32'(gi[0].avg_cm),    32'd511);
        check({tag, " avg_valid[0]"}, 32'(gi[0].avg_valid), 32'd0);
        check({tag, " near[0]"},      32'(gi[0].near),      32'd0);
        check({tag, " near_rise[0]"}, 32'(gi[0].near_rise), 32'd0);
        check({tag, " stale[0]"},     32'(gi[0].stale),     32'd1);
        check({tag, " avg_cm[1]"},    32'(gi[1].avg_cm),    32'd511);
        check({tag, " avg_valid[1]"}, 32'(gi[1].avg_valid), 32'd0);
        check({tag, " near[1]"},      32'(gi[1].near),      32'd0);
        check({tag, " near_rise[1]"}, 32'(gi[1].near_rise), 32'd0);
        check({tag, " stale[1]"},     32'(gi[1].stale),     32'd1);
    endtask

    initial begin
        int pat [6];
        int r;
        int v;
        for (int i = 0; i < NI; i++) begin
            exp_rises[i]  = 0;
            seen_rises[i] = 0;
        end
        model_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // Approach to 8 cm: depth-4 averages 385,259,133,8,8,8.
        repeat (6) send(8, 0);
        repeat (3) tick();
        check("near[0] after 8cm x6", 32'(gi[0].near), 32'd1);

        // Hysteresis band, then retreat: 14,16,18,20.
        repeat (4) send(12, 0);
        repeat (3) tick();
        repeat (4) send(20, 0);
        repeat (3) tick();
        check("near[0] after 20cm x4", 32'(gi[0].near), 32'd0);

        // Pending run broken by an outlier (visible on the depth-1 instance).
        repeat (4) send(100, 1);
        pat = '{5, 5, 50, 5, 5, 5};
        foreach (pat[i]) send(pat[i], 0);
        repeat (3) tick();
        check("near[1] after 5,5,50,5,5,5", 32'(gi[1].near), 32'd1);

        // Timeout from NEAR, then recovery with 300 cm.
        repeat (6) send(8, 0);
        repeat (TMO + 5) tick();
        check("stale[0] after timeout", 32'(gi[0].stale), 32'd1);
        check("near[0] after timeout", 32'(gi[0].near), 32'd0);
        send(300, 0);
        repeat (3) tick();
        check("stale[0] after 300", 32'(gi[0].stale), 32'd0);

        // Sample landing exactly on the expiry cycle.
        repeat (6) send(8, 0);
        repeat (TMO - 1) tick();
        send(8, 0);
        repeat (3) tick();
        check("stale[0] coincident", 32'(gi[0].stale), 32'd0);
        check("near[0] coincident", 32'(gi[0].near), 32'd1);

        // Saturation at and above DIST_MAX.
        send(4000, 0);
        send(65535, 2);
        send(511, 0);
        send(512, 0);
        repeat (3) tick();

        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 6)      v = $urandom_range(0, 25);
            else if (r < 8) v = $urandom_range(0, 600);
            else            v = $urandom_range(0, 65535);
            send(v, $urandom_range(0, 3));
        end
        repeat (3) tick();

        // Reset while the depth-4 instance is in NEAR_PEND.
        repeat (6) send(100, 0);
        repeat (5) send(8, 0);
        repeat (3) tick();
        check("q0 drained before reset", 32'(q0.size()), 32'd0);
        check("q1 drained before reset", 32'(q1.size()), 32'd0);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("async reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        repeat (6) send(8, 0);
        repeat (4) tick();

        for (int i = 0; i < NI; i++)
            check($sformatf("near_rise count[%0d]", i), 32'(seen_rises[i]), 32'(exp_rises[i]));
        check("q0 empty at end", 32'(q0.size()), 32'd0);
        check("q1 empty at end", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
